// File: rtl/alu_64bit.sv
// Registered 64-bit ALU execute stage: NOR, XOR, add-with-carry, subtract-with-carry.
// Latency: 1 cycle from an accepted input (in_valid) to s/cout/flags/out_valid.
// Backpressure: none; one operation per cycle, and results hold while in_valid is low.
// Optional flags: define ALU64_FLAGS_EN to compute and register zero/ovf; otherwise both are tied to 0.
module alu_64bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [63:0] a,
  input  logic [63:0] b,
  input  logic        cin,
  input  logic [1:0]  op,
  output logic [63:0] s,
  output logic        cout,
  output logic        out_valid,
  output logic        zero,
  output logic        ovf
);

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_e;

  op_e         w_op;
  logic        w_is_arith;
  logic [63:0] w_b_eff;
  logic [64:0] w_sum;
  logic [63:0] w_res;
  logic        w_cout;

  logic [63:0] r_s;
  logic        r_cout;
  logic        r_out_valid;

  assign w_op       = op_e'(op);
  assign w_is_arith = op[1];

  // Subtraction reuses the single adder by inverting B; a true a - b needs cin = 1.
  assign w_b_eff = (w_op == OP_SUB) ? ~b : b;
  assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {64'd0, cin};

  // Result mux: logic ops bypass the adder and never produce a carry.
  always_comb begin
    w_res  = 64'd0;
    w_cout = 1'b0;
    case (w_op)
      OP_NOR: w_res = ~(a | b);
      OP_XOR: w_res = a ^ b;
      OP_ADD, OP_SUB: begin
        w_res  = w_sum[63:0];
        w_cout = w_sum[64];
      end
      default: begin
        w_res  = 64'd0;
        w_cout = 1'b0;
      end
    endcase
  end

  // Output registers: reset clears, an accepted op loads, otherwise hold; out_valid pulses once per op.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s         <= 64'd0;
      r_cout      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s    <= w_res;
        r_cout <= w_cout;
      end
    end
  end

  assign s         = r_s;
  assign cout      = r_cout;
  assign out_valid = r_out_valid;

`ifdef ALU64_FLAGS_EN
  logic w_zero;
  logic w_ovf;
  logic r_zero;
  logic r_ovf;

  // Signed overflow: both adder inputs agree in sign but the result sign differs.
  assign w_zero = (w_res == 64'd0);
  assign w_ovf  = w_is_arith & (a[63] == w_b_eff[63]) & (w_sum[63] != a[63]);

  // Flag registers follow the same load/hold/reset rules as the result.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_zero <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (in_valid) begin
      r_zero <= w_zero;
      r_ovf  <= w_ovf;
    end
  end

  assign zero = r_zero;
  assign ovf  = r_ovf;
`else
  assign zero = 1'b0;
  assign ovf  = 1'b0;
`endif

endmodule

// File: tb/tb_alu_64bit.sv
// Self-checking bench for alu_64bit: directed cases plus randomized operations with reset.
// Reference model computes results with wide unsigned/signed arithmetic, one expected state per cycle.
// Inputs driven on the falling edge; outputs sampled on the following falling edge.
module tb_alu_64bit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [63:0] a;
  logic [63:0] b;
  logic        cin;
  logic [1:0]  op;
  logic [63:0] s;
  logic        cout;
  logic        out_valid;
  logic        zero;
  logic        ovf;

  int n_cmp = 0;
  int n_err = 0;

  // Expected registered state
  logic [63:0] exp_s;
  logic        exp_cout;
  logic        exp_zero;
  logic        exp_ovf;
  logic        exp_vld;

  alu_64bit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .op        (op),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid),
    .zero      (zero),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%016h expected 0x%016h", tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic [63:0] s;
    logic        cout;
    logic        zero;
    logic        ovf;
  } res_t;

  // Behavioural reference: arithmetic done on wide integers, overflow by range test.
  function automatic res_t ref_calc(input logic [63:0] ra, input logic [63:0] rb,
                                    input logic rcin, input logic [1:0] rop);
    res_t r;
    logic [64:0] u;
    logic signed [65:0] sv;
    logic signed [65:0] smax;
    logic signed [65:0] smin;
    logic [63:0] bx;
    r    = '0;
    smax = 66'sd9223372036854775807;
    smin = -66'sd9223372036854775807 - 66'sd1;
    bx   = (rop == 2'b11) ? ~rb : rb;
    case (rop)
      2'b00: r.s = ~(ra | rb);
      2'b01: r.s = ra ^ rb;
      default: begin
        u      = 65'(ra) + 65'(bx) + 65'(rcin);
        r.s    = u[63:0];
        r.cout = u[64];
        sv     = $signed({{2{ra[63]}}, ra}) + $signed({{2{bx[63]}}, bx}) + $signed({65'd0, rcin});
        r.ovf  = (sv > smax) || (sv < smin);
      end
    endcase
    r.zero = (r.s == 64'd0);
`ifndef ALU64_FLAGS_EN
    r.zero = 1'b0;
    r.ovf  = 1'b0;
`endif
    return r;
  endfunction

  // One clock: drive at the falling edge, advance the model, check at the next falling edge.
  task automatic step(input logic t_rst, input logic t_vld, input logic [63:0] t_a,
                      input logic [63:0] t_b, input logic t_cin, input logic [1:0] t_op,
                      input string tag);
    res_t r;
    rst      = t_rst;
    in_valid = t_vld;
    a        = t_a;
    b        = t_b;
    cin      = t_cin;
    op       = t_op;
    if (t_rst) begin
      exp_s = '0; exp_cout = 0; exp_zero = 0; exp_ovf = 0; exp_vld = 0;
    end else if (t_vld) begin
      r        = ref_calc(t_a, t_b, t_cin, t_op);
      exp_s    = r.s;
      exp_cout = r.cout;
      exp_zero = r.zero;
      exp_ovf  = r.ovf;
      exp_vld  = 1'b1;
    end else begin
      exp_vld = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".s"},         s,                  exp_s);
    chk({tag, ".cout"},      {63'd0, cout},      {63'd0, exp_cout});
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, exp_vld});
    chk({tag, ".zero"},      {63'd0, zero},      {63'd0, exp_zero});
    chk({tag, ".ovf"},       {63'd0, ovf},       {63'd0, exp_ovf});
  endtask

  function automatic logic [63:0] rand_operand();
    logic [63:0] v;
    case ($urandom_range(0, 5))
      0: v = 64'd0;
      1: v = 64'hFFFF_FFFF_FFFF_FFFF;
      2: v = 64'h8000_0000_0000_0000;
      3: v = 64'h7FFF_FFFF_FFFF_FFFF;
      default: v = {$urandom, $urandom};
    endcase
    return v;
  endfunction

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; op = 2'b00;
    @(negedge clk);

    // Reset with a live operation present: must be discarded
    step(1, 1, 64'h1234, 64'h5678, 1, 2'b10, "reset");

    // Directed cases
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFE, 64'd1, 0, 2'b10, "add_nocarry");
    chk("add_nocarry.lit", s, 64'hFFFF_FFFF_FFFF_FFFF);
    step(0, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 2'b10, "add_carry");
    chk("add_carry.lit", {63'd0, cout}, 64'd1);
    step(0, 1, 64'd5, 64'd7, 1, 2'b11, "sub_borrow");
    chk("sub_borrow.lit", s, 64'hFFFF_FFFF_FFFF_FFFE);
    step(0, 1, 64'h8000_0000_0000_0000, 64'd1, 1, 2'b11, "sub_ovf");
    chk("sub_ovf.lit", s, 64'h7FFF_FFFF_FFFF_FFFF);
    step(0, 1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd0, 1, 2'b10, "add_ovf_cin");
    step(0, 1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 1, 2'b00, "nor");
    chk("nor.lit", s, 64'h000F_000F_000F_000F);
    step(0, 1, 64'hF0F0_F0F0_F0F0_F0F0, 64'h0FF0_0FF0_0FF0_0FF0, 1, 2'b01, "xor");
    chk("xor.lit", s, 64'hFF00_FF00_FF00_FF00);
    step(0, 1, 64'hDEAD_BEEF_0000_0001, 64'hDEAD_BEEF_0000_0001, 0, 2'b01, "xor_zero");

    // Hold: one op then three idle cycles with changing inputs
    step(0, 1, 64'd100, 64'd23, 0, 2'b10, "hold_op");
    for (int i = 0; i < 3; i++)
      step(0, 0, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom), 2'($urandom), "hold_idle");
    chk("hold.lit", s, 64'd123);

    // Reset mid-stream then immediate resume
    step(1, 1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 0, 2'b10, "mid_reset");
    step(0, 1, 64'd40, 64'd2, 0, 2'b10, "resume");
    chk("resume.lit", s, 64'd42);

    // Randomized traffic with occasional resets and idle cycles
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0),
           rand_operand(), rand_operand(), 1'($urandom), 2'($urandom), "rand");

    // Back-to-back ops across all opcodes
    for (int i = 0; i < 40; i++)
      step(0, 1, rand_operand(), rand_operand(), 1'($urandom), 2'(i), "b2b");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
